// File: rtl/reduce_streak_detector.sv
// Registered AND/OR/XOR/NAND reduction of a WIDTH-bit word with a HOLD-sample streak detector.
// Optional macro DETECT_STICKY_EN: once detected, detect/b hold until clear or reset.
module reduce_streak_detector #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned HOLD  = 4,
    localparam int unsigned CNT_W = $clog2(HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             match,
    output logic             out_valid,
    output logic [CNT_W-1:0] streak,
    output logic             detect,
    output logic [WIDTH-1:0] b
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        DETECTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

    state_t           state, state_n;
    logic             match_n, out_valid_n, res;
    logic [CNT_W-1:0] streak_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            match     <= 1'b0;
            out_valid <= 1'b0;
            streak    <= '0;
        end else begin
            state     <= state_n;
            match     <= match_n;
            out_valid <= out_valid_n;
            streak    <= streak_n;
        end
    end

    always_comb begin
        res = 1'b0;
        case (mode)
            2'b00:   res = &a;
            2'b01:   res = |a;
            2'b10:   res = ^a;
            default: res = ~&a;
        endcase
    end

    always_comb begin
        state_n     = state;
        match_n     = match;
        out_valid_n = 1'b0;
        streak_n    = streak;
        if (clear) begin
            state_n  = IDLE;
            match_n  = 1'b0;
            streak_n = '0;
        end else if (in_valid) begin
            match_n     = res;
            out_valid_n = 1'b1;
            if (res)
                streak_n = (streak == HOLD_C) ? HOLD_C : streak + 1'b1;
            else
                streak_n = '0;
            // State is derived from the updated streak so HOLD=1 goes straight to DETECTED.
            if (streak_n == HOLD_C)
                state_n = DETECTED;
            else if (streak_n == '0)
                state_n = IDLE;
            else
                state_n = COUNT;
`ifdef DETECT_STICKY_EN
            if (state == DETECTED)
                state_n = DETECTED;
`endif
        end
    end

    assign detect = (state == DETECTED);
    assign b      = {WIDTH{detect}};

endmodule

// File: tb/tb_reduce_streak_detector.sv
// Directed self-checking bench for reduce_streak_detector (WIDTH=8, HOLD=4).
// Expectations follow DETECT_STICKY_EN when the bench is built with that macro.
module tb_reduce_streak_detector;

`ifdef DETECT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk, rst_n, in_valid, clear;
    logic [7:0] a;
    logic [1:0] mode;
    logic       match, out_valid, detect;
    logic [2:0] streak;
    logic [7:0] b;
    logic [13:0] obs;

    int errors = 0;
    int checks = 0;

    reduce_streak_detector #(.WIDTH(8), .HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .mode(mode),
        .clear(clear), .match(match), .out_valid(out_valid), .streak(streak),
        .detect(detect), .b(b)
    );

    assign obs = {match, out_valid, streak, detect, b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs expected {match,out_valid,streak,detect,b}; b is derived from detect.
    function automatic logic [13:0] ex(input logic m, input logic v, input logic [2:0] s, input logic d);
        return {m, v, s, d, {8{d}}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] av, input logic [1:0] mv);
        a = av; mode = mv; in_valid = 1'b1; clear = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; mode = 2'b00; clear = 1'b0;
        step();
        checks++;
        if (obs !== ex(0, 0, 0, 0))
            $display("FAIL reset_state: got %h expected %h", obs, ex(0, 0, 0, 0));
        if (obs !== ex(0, 0, 0, 0)) errors++;
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== ex(1, 1, 1, 0)) begin
            $display("FAIL reset_first_sample: got %h expected %h", obs, ex(1, 1, 1, 0));
            errors++;
        end
    endtask

    task automatic test_and_streak();
        logic [13:0] exp_v [5];
        exp_v[0] = ex(1, 1, 1, 0);
        exp_v[1] = ex(1, 1, 2, 0);
        exp_v[2] = ex(1, 1, 3, 0);
        exp_v[3] = ex(1, 1, 4, 1);
        exp_v[4] = ex(1, 1, 4, 1);
        do_clear();
        checks++;
        if (obs !== ex(0, 0, 0, 0)) begin
            $display("FAIL and_clear: got %h expected %h", obs, ex(0, 0, 0, 0));
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            sample(8'hFF, 2'b00);
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL and_streak[%0d]: got %h expected %h", i, obs, exp_v[i]);
                errors++;
            end
        end
    endtask

    task automatic test_break();
        sample(8'hFE, 2'b00);
        checks++;
        if (obs !== ex(0, 1, 0, STICKY)) begin
            $display("FAIL break: got %h expected %h", obs, ex(0, 1, 0, STICKY));
            errors++;
        end
        step();
        checks++;
        if (obs !== ex(0, 0, 0, STICKY)) begin
            $display("FAIL break_idle: got %h expected %h", obs, ex(0, 0, 0, STICKY));
            errors++;
        end
    endtask

    task automatic test_gaps_modes();
        logic [13:0] exp_v [6];
        exp_v[0] = ex(1, 1, 1, 0);
        exp_v[1] = ex(1, 0, 1, 0);
        exp_v[2] = ex(1, 0, 1, 0);
        exp_v[3] = ex(1, 1, 2, 0);
        exp_v[4] = ex(1, 1, 3, 0);
        exp_v[5] = ex(1, 1, 4, 1);
        do_clear();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: sample(8'h01, 2'b10);
                1, 2: step();
                3: sample(8'h07, 2'b10);
                4: sample(8'h80, 2'b10);
                default: sample(8'h0B, 2'b10);
            endcase
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL xor_gaps[%0d]: got %h expected %h", i, obs, exp_v[i]);
                errors++;
            end
        end
        sample(8'h00, 2'b01);
        checks++;
        if (obs !== ex(0, 1, 0, STICKY)) begin
            $display("FAIL or_break: got %h expected %h", obs, ex(0, 1, 0, STICKY));
            errors++;
        end
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < 4; i++) sample(8'hFF, 2'b00);
        checks++;
        if (obs !== ex(1, 1, 4, 1)) begin
            $display("FAIL clear_setup: got %h expected %h", obs, ex(1, 1, 4, 1));
            errors++;
        end
        clear = 1'b1; in_valid = 1'b1; a = 8'hFF; mode = 2'b00;
        step();
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (obs !== ex(0, 0, 0, 0)) begin
            $display("FAIL clear_with_valid: got %h expected %h", obs, ex(0, 0, 0, 0));
            errors++;
        end
    endtask

    task automatic test_nand_reset_mid();
        sample(8'hFF, 2'b11);
        checks++;
        if (obs !== ex(0, 1, 0, 0)) begin
            $display("FAIL nand_ff: got %h expected %h", obs, ex(0, 1, 0, 0));
            errors++;
        end
        sample(8'h7F, 2'b11);
        checks++;
        if (obs !== ex(1, 1, 1, 0)) begin
            $display("FAIL nand_7f: got %h expected %h", obs, ex(1, 1, 1, 0));
            errors++;
        end
        sample(8'h7F, 2'b11);
        sample(8'h00, 2'b11);
        checks++;
        if (obs !== ex(1, 1, 3, 0)) begin
            $display("FAIL nand_streak3: got %h expected %h", obs, ex(1, 1, 3, 0));
            errors++;
        end
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; mode = 2'b00;
        step();
        checks++;
        if (obs !== ex(0, 0, 0, 0)) begin
            $display("FAIL reset_mid: got %h expected %h", obs, ex(0, 0, 0, 0));
            errors++;
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        checks++;
        if (obs !== ex(0, 0, 0, 0)) begin
            $display("FAIL reset_after: got %h expected %h", obs, ex(0, 0, 0, 0));
            errors++;
        end
        sample(8'hFF, 2'b00);
        checks++;
        if (obs !== ex(1, 1, 1, 0)) begin
            $display("FAIL reset_restart: got %h expected %h", obs, ex(1, 1, 1, 0));
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_and_streak();
        test_break();
        test_gaps_modes();
        test_clear();
        test_nand_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
